md_iter: RTL

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the multi-cycle CPU.

---
 rtl/md_iter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/md_iter.sv
`default_nettype none
// ============================================================================
// Module      : md_iter
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               Multiply has a fixed, parameterised latency; divide is a
//               radix-2 restoring divider producing one quotient bit per
//               cycle, with sign fix-up folded into the final step.
// Revision    : 1.0 - initial release
// ============================================================================
module md_iter #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       md_control,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // The shared down-counter must cover the longer of the two operations.
    localparam int c_max_cycles = (MULT_CYCLES > WIDTH) ? MULT_CYCLES : WIDTH;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mul  = 2'd1;
    localparam logic [1:0] c_div  = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    // r_a: multiplicand, or dividend magnitude shifting into the quotient.
    // r_b: multiplier, or divisor magnitude.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic               r_sgn;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;

    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_q_fin;
    logic [WIDTH-1:0]   w_r_fin;

    // Operand magnitudes, product, and one restoring divide step.
    always_comb begin
        w_rs_neg  = ~md_control[0] & rs[WIDTH-1];
        w_rt_neg  = ~md_control[0] & rt[WIDTH-1];
        w_rs_mag  = w_rs_neg ? -rs : rs;
        w_rt_mag  = w_rt_neg ? -rt : rt;
        w_a_ext   = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
        w_b_ext   = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
        w_prod    = w_a_ext * w_b_ext;
        // Bit WIDTH of the difference is the borrow: set when trial < divisor.
        w_trial   = {r_rem, r_a[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_b};
        w_fits    = ~w_diff[WIDTH];
        w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_quo_nxt = {r_a[WIDTH-2:0], w_fits};
        // Most-negative / -1 needs no special case: the magnitude quotient
        // 2^(WIDTH-1) is not negated and reads back as the most-negative value.
        w_q_fin   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
        w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    // Control FSM, operand capture, iteration and HI/LO write-back.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        case (md_control)
                            3'b000, 3'b001: begin
                                r_state <= c_mul;
                                r_busy  <= 1'b1;
                                r_cnt   <= c_mul_last;
                                r_sgn   <= ~md_control[0];
                                r_a     <= rs;
                                r_b     <= rt;
                            end
                            3'b010, 3'b011: begin
                                r_state <= c_div;
                                r_busy  <= 1'b1;
                                r_cnt   <= c_div_last;
                                r_sgn   <= 1'b0;
                                r_a     <= w_rs_mag;
                                r_b     <= w_rt_mag;
                                r_rem   <= '0;
                                r_neg_q <= w_rs_neg ^ w_rt_neg;
                                r_neg_r <= w_rs_neg;
                                r_zero  <= (rt == '0);
                            end
                            3'b100:  r_hi <= rs;
                            3'b101:  r_lo <= rs;
                            default: ;
                        endcase
                    end
                end
                c_mul: begin
                    if (abort) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo    <= w_prod[WIDTH-1:0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_div: begin
                    if (abort) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_a   <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        if (r_cnt == '0) begin
                            r_state <= c_idle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_dz    <= r_zero;
                            if (!r_zero) begin
                                r_lo <= w_q_fin;
                                r_hi <= w_r_fin;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire
